// File: rtl/cache_test_console.sv
// Front-panel console for exercising a cache: switch-driven single requests,
// auto address sweep, hit/miss counters, response timeout and hex display.
module cache_test_console #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TO_CYC   = 255,
  parameter int unsigned HOLD_CYC = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     sw_addr,
  input  logic [DATA_W-1:0]     sw_data,
  input  logic                  sw_wr,
  input  logic                  btn_go,
  input  logic                  sweep,
  input  logic [1:0]            disp_sel,
  output logic                  cache_req,
  output logic [ADDR_W-1:0]     cache_addr,
  output logic [DATA_W-1:0]     cache_wdata,
  output logic                  cache_wr,
  input  logic                  cache_done,
  input  logic [DATA_W-1:0]     cache_rdata,
  input  logic                  cache_miss,
  output logic [8*(DATA_W/4)-1:0] seg,
  output logic                  busy,
  output logic                  to_err
);

  localparam int unsigned NDIG   = DATA_W / 4;
  localparam int unsigned DISP_W = 4 * NDIG;
  localparam int unsigned WC_W   = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
  localparam int unsigned HC_W   = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SHOW,
    ST_HOLD
  } state_t;

  state_t state, state_d;

  logic btn_s1, btn_s2, btn_s3;
  logic go_pulse;

  logic [WC_W-1:0]   wait_cnt;
  logic [HC_W-1:0]   hold_cnt;
  logic [DATA_W-1:0] cap_data;
  logic              last_miss;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  logic load_sw, load_next, capture, timeout;
  logic [DISP_W-1:0] disp_val;

  // Button synchronizer plus previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      btn_s1 <= btn_go;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign go_pulse = btn_s2 & ~btn_s3;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d   = state;
    load_sw   = 1'b0;
    load_next = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go_pulse) begin
          load_sw = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cache_done) begin
          capture = 1'b1;
          state_d = ST_SHOW;
        end else if (wait_cnt == WC_W'(TO_CYC - 1)) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SHOW: state_d = sweep ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (hold_cnt == HC_W'(HOLD_CYC - 1)) begin
          if (sweep) begin
            load_next = 1'b1;
            state_d   = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request registers, handshake outputs and residency counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_addr  <= '0;
      cache_wdata <= '0;
      cache_wr    <= 1'b0;
      cache_req   <= 1'b0;
      busy        <= 1'b0;
      to_err      <= 1'b0;
      wait_cnt    <= '0;
      hold_cnt    <= '0;
    end else begin
      if (load_sw) begin
        cache_addr  <= sw_addr;
        cache_wdata <= sw_data;
        cache_wr    <= sw_wr;
      end else if (load_next) begin
        cache_addr  <= cache_addr + ADDR_W'(1);
        cache_wdata <= sw_data;
        cache_wr    <= sw_wr;
      end
      cache_req <= (state_d == ST_REQ);
      busy      <= (state_d == ST_REQ) || (state_d == ST_WAIT);
      if (timeout)      to_err <= 1'b1;
      else if (load_sw) to_err <= 1'b0;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + WC_W'(1) : '0;
      hold_cnt <= (state == ST_HOLD) ? hold_cnt + HC_W'(1) : '0;
    end
  end

  // Result capture and saturating hit/miss counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data  <= '0;
      last_miss <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else if (capture) begin
      cap_data  <= cache_wr ? cache_wdata : cache_rdata;
      last_miss <= cache_miss;
      if (cache_miss) begin
        if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
      end else begin
        if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_W'(1);
      end
    end
  end

  // Hex digit to active-low {g..a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Display source select and per-nibble decode; dp0 marks a miss
  always_comb begin
    case (disp_sel)
      2'd0:    disp_val = DISP_W'(cap_data);
      2'd1:    disp_val = DISP_W'(hit_cnt);
      2'd2:    disp_val = DISP_W'(miss_cnt);
      default: disp_val = DISP_W'(cache_addr);
    endcase
    seg = '1;
    for (int k = 0; k < int'(NDIG); k++) begin
      seg[8*k +: 7] = hex7(disp_val[4*k +: 4]);
    end
    seg[7] = ~last_miss;
  end

endmodule

// File: tb/tb_cache_test_console.sv
// Scoreboard bench for cache_test_console: expected requests and responses
// are queued by the stimulus and checked by a monitor on DUT activity.
module tb_cache_test_console;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 20;
  localparam int unsigned HC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] sw_addr = '0;
  logic [DW-1:0] sw_data = '0;
  logic          sw_wr = 1'b0;
  logic          btn_go = 1'b0;
  logic          sweep = 1'b0;
  logic [1:0]    disp_sel = 2'd0;
  logic          cache_req;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata;
  logic          cache_wr;
  logic          cache_done = 1'b0;
  logic [DW-1:0] cache_rdata = '0;
  logic          cache_miss = 1'b0;
  logic [15:0]   seg;
  logic          busy;
  logic          to_err;

  logic          s_req, s_wr, s_busy, s_to;
  logic [AW-1:0] s_addr;
  logic [3:0]    s_wdata;
  logic [7:0]    s_seg;

  cache_test_console #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16), .TO_CYC(TO), .HOLD_CYC(HC)) dut (
    .clk(clk), .rst_n(rst_n), .sw_addr(sw_addr), .sw_data(sw_data), .sw_wr(sw_wr),
    .btn_go(btn_go), .sweep(sweep), .disp_sel(disp_sel), .cache_req(cache_req),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_wr(cache_wr),
    .cache_done(cache_done), .cache_rdata(cache_rdata), .cache_miss(cache_miss),
    .seg(seg), .busy(busy), .to_err(to_err)
  );

  // Narrow copy with 4-bit counters, run in lockstep for the saturation check
  cache_test_console #(.ADDR_W(AW), .DATA_W(4), .CNT_W(4), .TO_CYC(TO), .HOLD_CYC(HC)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sw_addr(sw_addr), .sw_data(sw_data[3:0]), .sw_wr(sw_wr),
    .btn_go(btn_go), .sweep(sweep), .disp_sel(disp_sel), .cache_req(s_req),
    .cache_addr(s_addr), .cache_wdata(s_wdata), .cache_wr(s_wr),
    .cache_done(cache_done), .cache_rdata(cache_rdata[3:0]), .cache_miss(cache_miss),
    .seg(s_seg), .busy(s_busy), .to_err(s_to)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
  } req_t;

  typedef struct packed {
    logic [15:0] seg;
    logic        to_err;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t last_req;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_req = 0;
  int last_req_cyc = -1;
  bit gap_chk = 1'b0;
  bit prev_busy = 1'b0;

  logic          resp_en = 1'b0;
  int            resp_lat = 3;
  logic [DW-1:0] resp_rdata = '0;
  logic          resp_miss = 1'b0;
  int            kick_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic exp_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    req_t r;
    r.addr = a; r.wdata = d; r.wr = w;
    req_q.push_back(r);
  endtask

  task automatic exp_rsp(input logic [15:0] s, input logic e);
    rsp_t r;
    r.seg = s; r.to_err = e;
    rsp_q.push_back(r);
  endtask

  // Cache model: answers each request after resp_lat cycles, or a stray strobe on kick
  always begin : responder
    int kick_seen;
    kick_seen = 0;
    forever begin
      @(negedge clk);
      if (kick_cnt != kick_seen) begin
        kick_seen = kick_cnt;
        cache_rdata = resp_rdata;
        cache_miss  = resp_miss;
        cache_done  = 1'b1;
        @(negedge clk);
        cache_done  = 1'b0;
      end else if (cache_req && resp_en) begin
        repeat (resp_lat) @(negedge clk);
        cache_rdata = resp_rdata;
        cache_miss  = resp_miss;
        cache_done  = 1'b1;
        @(negedge clk);
        cache_done  = 1'b0;
      end
    end
  end

  // Monitor: request pulses, held request fields at done, results at busy fall
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (cache_req) begin
        n_req++;
        if (gap_chk && last_req_cyc >= 0)
          chk("sweep_gap", 32'(cyc - last_req_cyc > int'(HC)), 32'd1);
        last_req_cyc = cyc;
        if (req_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %h want no request", cache_addr);
        end else begin
          last_req = req_q.pop_front();
          chk("req_addr", 32'(cache_addr), 32'(last_req.addr));
          chk("req_wdata", 32'(cache_wdata), 32'(last_req.wdata));
          chk("req_wr", 32'(cache_wr), 32'(last_req.wr));
        end
      end
      if (cache_done && resp_en) begin
        chk("held_addr", 32'(cache_addr), 32'(last_req.addr));
        chk("held_wdata", 32'(cache_wdata), 32'(last_req.wdata));
        chk("held_wr", 32'(cache_wr), 32'(last_req.wr));
      end
      if (prev_busy && !busy) begin
        if (rsp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got seg %h want no response", seg);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_seg", 32'(seg), 32'(r.seg));
          chk("rsp_to_err", 32'(to_err), 32'(r.to_err));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic press();
    btn_go = 1'b1;
    repeat (3) @(negedge clk);
    btn_go = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_req_issued(input int max);
    int k = 0;
    while (req_q.size() != 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("req_issued", 32'(req_q.size() == 0), 32'd1);
  endtask

  task automatic wait_quiet(input int max);
    int k = 0;
    while (!(req_q.size() == 0 && rsp_q.size() == 0 && !busy && !cache_done) && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("quiet", 32'(req_q.size() == 0 && rsp_q.size() == 0 && !busy), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic disp(input logic [1:0] sel, input logic [15:0] exp, input string nm);
    disp_sel = sel;
    #1;
    chk(nm, 32'(seg), 32'(exp));
  endtask

  initial begin : stim
    int base;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h0000C0C0);
    chk("rst_sat_seg", 32'(s_seg), 32'h000000C0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_to_err", 32'(to_err), 32'd0);
    chk("rst_req", 32'(cache_req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read hit at 0x05 returning 0xA7
    sw_addr = 7'h05; sw_data = 8'h99; sw_wr = 1'b0;
    resp_en = 1'b1; resp_lat = 3; resp_rdata = 8'hA7; resp_miss = 1'b0;
    exp_req(7'h05, 8'h99, 1'b0);
    exp_rsp(16'h88F8, 1'b0);
    press();
    wait_quiet(60);
    disp(2'd1, 16'hC0F9, "hit_cnt_1");
    disp(2'd2, 16'hC0C0, "miss_cnt_0");
    disp(2'd3, 16'hC092, "addr_05");
    disp_sel = 2'd0;

    // Write miss of 0x3C: display shows written data, dp0 lit
    sw_addr = 7'h12; sw_data = 8'h3C; sw_wr = 1'b1;
    resp_rdata = 8'hFF; resp_miss = 1'b1;
    exp_req(7'h12, 8'h3C, 1'b1);
    exp_rsp(16'hB046, 1'b0);
    press();
    wait_quiet(60);
    disp(2'd2, 16'hC079, "miss_cnt_1");
    disp(2'd1, 16'hC079, "hit_cnt_still_1");
    disp_sel = 2'd0;

    // Timeout: no response, display unchanged, to_err until next press
    resp_en = 1'b0;
    sw_addr = 7'h20; sw_data = 8'h00; sw_wr = 1'b0;
    exp_req(7'h20, 8'h00, 1'b0);
    exp_rsp(16'hB046, 1'b1);
    press();
    wait_quiet(int'(TO) + 40);
    repeat (5) @(negedge clk);
    chk("to_err_sticky", 32'(to_err), 32'd1);
    resp_en = 1'b1; resp_lat = 2; resp_rdata = 8'h4D; resp_miss = 1'b0;
    sw_addr = 7'h21;
    exp_req(7'h21, 8'h00, 1'b0);
    exp_rsp(16'h99A1, 1'b0);
    press();
    chk("to_err_cleared", 32'(to_err), 32'd0);
    wait_quiet(60);

    // Sweep from 0x7E across the address wrap
    base = n_req;
    sweep = 1'b1; sw_addr = 7'h7E; resp_rdata = 8'h5A;
    exp_req(7'h7E, 8'h00, 1'b0);
    exp_req(7'h7F, 8'h00, 1'b0);
    exp_req(7'h00, 8'h00, 1'b0);
    repeat (3) exp_rsp(16'h9288, 1'b0);
    gap_chk = 1'b1; last_req_cyc = -1;
    press();
    wait_req_issued(200);
    sweep = 1'b0;
    wait_quiet(100);
    repeat (20) @(negedge clk);
    gap_chk = 1'b0;
    chk("sweep_req_count", 32'(n_req - base), 32'd3);
    disp(2'd3, 16'hC0C0, "addr_wrapped_00");
    disp_sel = 2'd0;

    // Reset in WAIT, then a stray late strobe
    resp_en = 1'b0; sw_addr = 7'h30;
    exp_req(7'h30, 8'h00, 1'b0);
    press();
    wait_req_issued(20);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_req", 32'(cache_req), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    kick_cnt++;
    repeat (4) @(negedge clk);
    disp(2'd1, 16'hC0C0, "hit_after_late_done");
    disp(2'd2, 16'hC0C0, "miss_after_late_done");
    disp(2'd0, 16'hC0C0, "data_after_late_done");

    // 17 hits: first with a second press during WAIT that must be ignored
    resp_en = 1'b1; resp_rdata = 8'h11; resp_miss = 1'b0;
    for (int i = 0; i < 17; i++) begin
      resp_lat = (i == 0) ? 10 : 1;
      sw_addr = 7'(i);
      exp_req(7'(i), 8'h00, 1'b0);
      exp_rsp(16'hF9F9, 1'b0);
      press();
      if (i == 0) begin
        wait_req_issued(20);
        press();
      end
      wait_quiet(100);
    end
    disp(2'd1, 16'hF9F9, "hit_cnt_17");
    chk("sat_hit_cnt_15", 32'(s_seg), 32'h0000008E);
    disp(2'd2, 16'hC0C0, "miss_cnt_still_0");
    chk("sat_miss_cnt_0", 32'(s_seg), 32'h000000C0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_test_console.md
CACHE_TEST_CONSOLE -- requirements
Module: cache_test_console

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning data width; it is a multiple of 4. NDIG = DATA_W/4.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning hit/miss counter width (CNT_W >= DATA_W).
REQ-004 The block SHALL have parameter TO_CYC, default 255, meaning the response timeout in cycles.
REQ-005 The block SHALL have parameter HOLD_CYC, default 15, meaning the sweep-mode display hold in cycles.
REQ-006 Ports SHALL be one per line as follows:
clk  in  1  sole clock; all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
sw_addr  in  ADDR_W  switch address
sw_data  in  DATA_W  switch write data
sw_wr  in  1  1=write, 0=read
btn_go  in  1  raw pushbutton, asynchronous, active-high
sweep  in  1  1=auto address sweep
disp_sel  in  2  0=data, 1=hit count, 2=miss count, 3=address
cache_req  out  1  one-cycle request pulse
cache_addr  out  ADDR_W  request address, held stable from req to done
cache_wdata  out  DATA_W  request data, held stable from req to done
cache_wr  out  1  request write flag, held stable from req to done
cache_done  in  1  one-cycle response strobe
cache_rdata  in  DATA_W  response data, valid with cache_done
cache_miss  in  1  miss flag, valid with cache_done
seg  out  8*NDIG  active-low 7-seg; digit k = seg[8k+7:8k]; bits 0-6 = a-g; bit 7 = dp
busy  out  1  request outstanding
to_err  out  1  sticky timeout flag

Function
REQ-007 btn_go SHALL pass a 2-flop synchronizer, then a rising-edge detector; go_pulse is high for one cycle per press.
REQ-008 The FSM SHALL have the states IDLE, REQ, WAIT, SHOW and HOLD.
REQ-009 IDLE SHALL go to REQ on go_pulse and latch sw_addr, sw_data and sw_wr into the request registers.
REQ-010 REQ SHALL assert cache_req for exactly one cycle and go to WAIT; busy SHALL be 1 in REQ and WAIT only.
REQ-011 WAIT SHALL go to SHOW on cache_done, capturing cache_rdata (reads) or the written data (writes) and cache_miss.
REQ-012 In WAIT, a wait counter that reaches TO_CYC cycles without cache_done SHALL set to_err and go to IDLE, leaving the display unchanged.
REQ-013 to_err SHALL clear only on reset or on the next go_pulse.
REQ-014 On cache_done, miss_cnt SHALL increment if cache_miss=1, otherwise hit_cnt SHALL increment; both counters saturate at 2^CNT_W-1 with no wrap.
REQ-015 SHOW SHALL go to IDLE in the next cycle when sweep=0, and to HOLD when sweep=1.
REQ-016 HOLD SHALL wait HOLD_CYC cycles, then load addr+1 (2^ADDR_W-1 wraps to 0) with the current sw_data and sw_wr, and go to REQ.
REQ-017 If sweep drops during HOLD, the FSM SHALL return to IDLE at the end of HOLD.
REQ-018 go_pulse SHALL be ignored in every state other than IDLE, with no queuing.
REQ-019 A cache_done outside WAIT SHALL be ignored and SHALL NOT update the counters.
REQ-020 Display SHALL be combinational from registered state, decoded per nibble as hex: digit k shows value[4k+3:4k] of the disp_sel source, with the address zero-extended and the counters truncated to 4*NDIG LSBs.
REQ-021 Hex patterns SHALL be active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 The dp of digit 0 SHALL be 0 (lit) when the last captured result was a miss; all other dp SHALL be 1.

Reset
REQ-023 rst_n=0 SHALL asynchronously force: FSM=IDLE, the synchronizer flops to 0, cache_req/busy/to_err=0, the request registers and captured data to 0, hit_cnt/miss_cnt=0, and the last-miss flag to 0.
REQ-024 After reset, seg SHALL show all digits "0" with every dp=1.
REQ-025 Reset during WAIT SHALL abandon the request; a later cache_done SHALL be ignored.

Verification
REQ-026 Read hit: sw_addr=0x05, sw_wr=0, press; cache_done after 3 cycles, rdata=0xA7, miss=0; disp_sel=0 -> cache_req 1 cycle, seg shows "A7", dp0=1, hit_cnt=1.
REQ-027 Write miss: sw_wr=1, sw_data=0x3C, press; done with miss=1 -> seg shows "3C", dp0=0, miss_cnt=1, cache_wr=1 held until done.
REQ-028 Timeout: press with cache_done never asserted -> to_err=1 after TO_CYC cycles, FSM in IDLE; next press -> to_err=0.
REQ-029 Sweep wrap: sweep=1, start addr 0x7E -> requests issued to 0x7E, 0x7F, 0x00, each separated by HOLD_CYC+ cycles.
REQ-030 Saturation: CNT_W=4, 17 hits -> hit_cnt=15; press during WAIT ignored (one cache_req only).
REQ-031 Async reset mid-WAIT: assert rst_n=0 -> busy=0 immediately; a late cache_done causes no counter change.
